// File: rtl/seg7_pkg.sv
// Shared state encoding and segment constants for the two-digit scanner.
package seg7_pkg;

  typedef enum logic [1:0] {
    S_ONES = 2'd0,
    S_GAP1 = 2'd1,
    S_TENS = 2'd2,
    S_GAP0 = 2'd3
  } state_t;

  // Segment patterns are {g,f,e,d,c,b,a}, active-low.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Index 0 is the rightmost entry.
  localparam logic [9:0][6:0] SEG_DIGIT = '{
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  // Digit enables, active-low: bit 0 ones, bit 1 tens.
  localparam logic [1:0] DIG_ONES = 2'b10;
  localparam logic [1:0] DIG_TENS = 2'b01;
  localparam logic [1:0] DIG_OFF  = 2'b11;

endpackage

// File: rtl/seg7_decode.sv
// Nibble to active-low 7-segment pattern; A-F show a dash.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  // Pure lookup; out-of-range nibbles map to the dash.
  always_comb begin
    seg = SEG_DASH;
    if (nib < 4'd10) seg = SEG_DIGIT[nib];
  end

endmodule

// File: rtl/seg7_scan.sv
// Two-digit multiplexed 7-segment scanner with dead-time gaps between
// digits and a per-frame shadow capture of the BCD input.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int LZB      = 1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] Q_IN,
  output logic [6:0] SEG,
  output logic [1:0] DIG
);

  localparam int CW = $clog2(SCAN_DIV);

  logic [CW-1:0] cnt;
  logic          tick;
  state_t        state, state_nx;
  logic [7:0]    shadow, shadow_nx;
  logic [3:0]    nib;
  logic [6:0]    seg_dec;

  assign tick = (cnt == CW'(SCAN_DIV - 1));

  // Free-running prescaler; tick on the terminal count.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)    cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

  // Next state, next shadow and the nibble shown in the next state, so the
  // registered outputs land on the same edge as the state change.
  always_comb begin
    state_nx  = state;
    shadow_nx = shadow;
    case (state)
      S_ONES: if (tick) state_nx = S_GAP1;
      S_GAP1: state_nx = S_TENS;
      S_TENS: if (tick) state_nx = S_GAP0;
      S_GAP0: begin
        state_nx  = S_ONES;
        shadow_nx = Q_IN;
      end
      default: state_nx = S_GAP0;
    endcase
    nib = (state_nx == S_TENS) ? shadow_nx[7:4] : shadow_nx[3:0];
  end

  seg7_decode u_dec (
    .nib (nib),
    .seg (seg_dec)
  );

  // Scan FSM with registered segment/digit drive.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state  <= S_GAP0;
      shadow <= 8'h00;
      SEG    <= SEG_BLANK;
      DIG    <= DIG_OFF;
    end else begin
      state  <= state_nx;
      shadow <= shadow_nx;
      case (state_nx)
        S_ONES: begin
          DIG <= DIG_ONES;
          SEG <= seg_dec;
        end
        S_TENS: begin
          DIG <= DIG_TENS;
          SEG <= (LZB != 0 && shadow_nx[7:4] == 4'h0) ? SEG_BLANK : seg_dec;
        end
        default: begin
          DIG <= DIG_OFF;
          SEG <= SEG_BLANK;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan at SCAN_DIV=4; one instance per LZB setting.
module tb_seg7_scan;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] Q_IN;
  logic [6:0] SEG, SEG0;
  logic [1:0] DIG, DIG0;
  int         n_tests = 0;
  int         n_fail  = 0;

  localparam logic [6:0] B  = 7'h7F;
  localparam logic [6:0] DS = 7'b0111111;
  localparam logic [6:0] D0 = 7'b1000000;
  localparam logic [6:0] D1 = 7'b1111001;
  localparam logic [6:0] D2 = 7'b0100100;
  localparam logic [6:0] D3 = 7'b0110000;
  localparam logic [6:0] D4 = 7'b0011001;
  localparam logic [6:0] D5 = 7'b0010010;
  localparam logic [6:0] D7 = 7'b1111000;
  localparam logic [6:0] D8 = 7'b0000000;
  localparam logic [6:0] D9 = 7'b0010000;

  always #5 CLK = ~CLK;

  seg7_scan #(.SCAN_DIV(4), .LZB(1)) dut (
    .CLK(CLK), .RESET(RESET), .Q_IN(Q_IN), .SEG(SEG), .DIG(DIG)
  );

  seg7_scan #(.SCAN_DIV(4), .LZB(0)) dut0 (
    .CLK(CLK), .RESET(RESET), .Q_IN(Q_IN), .SEG(SEG0), .DIG(DIG0)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // Check both outputs of the LZB=1 instance.
  task automatic chk1(input string tag, input logic [1:0] d, input logic [6:0] s);
    chk({tag, ".dig"}, {6'd0, DIG}, {6'd0, d});
    chk({tag, ".seg"}, {1'b0, SEG}, {1'b0, s});
  endtask

  // Advance n rising edges, landing 1 time unit after the last one.
  task automatic clk(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    RESET = 1'b0;
    Q_IN  = 8'h37;
    #12;
    chk1("rst_hold", 2'b11, B);
    chk("rst_hold_lzb0", {1'b0, SEG0}, {1'b0, B});
    clk(1);
    chk1("rst_hold_clk", 2'b11, B);
    RESET = 1'b1;

    // Frame 1: value 37, edges 1..8
    clk(1); chk1("e1_ones", 2'b10, D7);
    clk(1); chk1("e2_ones", 2'b10, D7);
    clk(1); chk1("e3_ones", 2'b10, D7);
    clk(1); chk1("e4_gap1", 2'b11, B);
    clk(1); chk1("e5_tens", 2'b01, D3);
    clk(1); chk1("e6_tens", 2'b01, D3);
    clk(1); chk1("e7_tens", 2'b01, D3);
    clk(1); chk1("e8_gap0", 2'b11, B);
    clk(1); chk1("e9_ones_frame", 2'b10, D7);

    // Leading-zero blanking: 05 captured at edge 16->17
    Q_IN = 8'h05;
    clk(8); chk1("blank_ones", 2'b10, D5);
    chk("blank_ones_lzb0", {1'b0, SEG0}, {1'b0, D5});
    clk(4); chk1("blank_tens", 2'b01, B);
    chk("noblank_tens_dig", {6'd0, DIG0}, 8'h01);
    chk("noblank_tens_seg", {1'b0, SEG0}, {1'b0, D0});

    // Invalid nibble
    Q_IN = 8'h2E;
    clk(4); chk1("dash_ones", 2'b10, DS);
    clk(4); chk1("dash_tens", 2'b01, D2);

    // Tear-free: change input mid ones phase
    Q_IN = 8'h12;
    clk(4); chk1("tear_ones", 2'b10, D2);
    clk(1); Q_IN = 8'h34;
    clk(3); chk1("tear_tens", 2'b01, D1);
    clk(4); chk1("next_ones", 2'b10, D4);
    clk(4); chk1("next_tens", 2'b01, D3);

    // Mid-operation reset during tens phase
    #2;
    RESET = 1'b0;
    Q_IN  = 8'h89;
    #1;
    chk1("midrst_async", 2'b11, B);
    clk(2); chk1("midrst_hold", 2'b11, B);
    RESET = 1'b1;
    clk(1); chk1("restart_ones", 2'b10, D9);
    clk(3); chk1("restart_gap", 2'b11, B);
    clk(1); chk1("restart_tens", 2'b01, D8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
